// File: rtl/fifo_service_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
// Shared definitions for the FIFO service scheduler:
//   CHAN_COUNT      - number of round-robin channels (8 write-side + 8 read-side)
//   DIR_WRITE/READ  - grant direction encodings
//   sched_state_t   - scheduler FSM state encoding
//   fifo_level()    - FIFO occupancy from an in/out pointer pair, modulo 2^width
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

  localparam int CHAN_COUNT     = 16;
  localparam int SIDE_COUNT     = 8;
  localparam int MAX_ADDR_WIDTH = 16;

  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } sched_state_t;

  // Pointer difference in MAX_ADDR_WIDTH bits. Callers zero-extend narrower
  // pointers and keep only their low ADDR_WIDTH bits of the result, which is
  // exactly (in - out) mod 2^ADDR_WIDTH.
  function automatic logic [MAX_ADDR_WIDTH-1:0] fifo_level(
    input logic [MAX_ADDR_WIDTH-1:0] in_addr,
    input logic [MAX_ADDR_WIDTH-1:0] out_addr
  );
    return in_addr - out_addr;
  endfunction

endpackage

// File: rtl/fifo_service_scheduler_if.sv
// -----------------------------------------------------------------------------
// fifo_service_scheduler_if
// Grant handshake between the scheduler and the memory arbitrator.
//   grant_valid/grant_ready - one-deep offer/accept handshake
//   grant_dir/chan/len      - which FIFO to service and how many bytes
//   xfer_done               - arbitrator pulse closing the accepted transfer
//   busy                    - an accepted transfer is in flight
// Modports: master = scheduler side, slave = arbitrator side.
// -----------------------------------------------------------------------------
interface fifo_service_scheduler_if #(
  parameter int ADDR_WIDTH = 11
) ();

  logic                  grant_valid;
  logic                  grant_ready;
  logic                  grant_dir;
  logic [2:0]            grant_chan;
  logic [ADDR_WIDTH-1:0] grant_len;
  logic                  xfer_done;
  logic                  busy;

  modport master (
    output grant_valid,
    output grant_dir,
    output grant_chan,
    output grant_len,
    output busy,
    input  grant_ready,
    input  xfer_done
  );

  modport slave (
    input  grant_valid,
    input  grant_dir,
    input  grant_chan,
    input  grant_len,
    input  busy,
    output grant_ready,
    output xfer_done
  );

endinterface

// File: rtl/fifo_service_scheduler_rr_pick16.sv
// -----------------------------------------------------------------------------
// rr_pick16
// Combinational rotating priority encoder over 16 requests.
//   req   in 16 : request vector
//   start in 4  : highest-priority position this cycle
//   found out 1 : at least one request is set
//   idx   out 4 : first set request at or after start, wrapping 15 -> 0
// -----------------------------------------------------------------------------
module rr_pick16
  import fifo_sched_pkg::*;
(
  input  logic [CHAN_COUNT-1:0] req,
  input  logic [3:0]            start,
  output logic                  found,
  output logic [3:0]            idx
);

  logic [3:0] cand_s;

  // Scan positions start, start+1, ... and keep the first hit.
  always_comb begin
    found  = 1'b0;
    idx    = 4'd0;
    cand_s = 4'd0;
    for (int i = 0; i < CHAN_COUNT; i++) begin
      cand_s = start + 4'(i);
      if (!found && req[cand_s]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_service_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_service_scheduler
// Picks the next tracking FIFO for the memory arbitrator and offers one burst
// grant at a time, round-robin over 8 write-side and 8 read-side channels.
//   clk, reset (async, active-low)
//   write_in_addrs/write_out_addrs : write-side FIFO pointers (data -> RAM)
//   read_in_addrs/read_out_addrs   : read-side FIFO pointers (RAM -> data)
//   chan_enable[15:0]              : per-channel enable, [7:0] write, [15:8] read
//   flush_req[7:0]                 : allow a partial burst on write channel k
//   gnt (master)                   : grant handshake to the arbitrator
// Channel index {dir, chan}: 0..7 write channels, 8..15 read channels.
// -----------------------------------------------------------------------------
module fifo_service_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int BURST_BYTES = 64,
  parameter int ADDR_WIDTH  = 11
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [SIDE_COUNT*ADDR_WIDTH-1:0]  write_in_addrs,
  input  logic [SIDE_COUNT*ADDR_WIDTH-1:0]  write_out_addrs,
  input  logic [SIDE_COUNT*ADDR_WIDTH-1:0]  read_in_addrs,
  input  logic [SIDE_COUNT*ADDR_WIDTH-1:0]  read_out_addrs,
  input  logic [CHAN_COUNT-1:0]             chan_enable,
  input  logic [SIDE_COUNT-1:0]             flush_req,
  fifo_service_scheduler_if.master          gnt
);

  localparam logic [ADDR_WIDTH-1:0] BURST_LEN = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] CAPACITY  = {ADDR_WIDTH{1'b1}};

  // Per-channel level / free space
  logic [ADDR_WIDTH-1:0] wr_level_s [SIDE_COUNT];
  logic [ADDR_WIDTH-1:0] rd_free_s  [SIDE_COUNT];

  // Eligibility pipeline
  logic [CHAN_COUNT-1:0]                 elig_s;
  logic [CHAN_COUNT-1:0]                 elig_r;
  logic [CHAN_COUNT-1:0][ADDR_WIDTH-1:0] len_s;
  logic [CHAN_COUNT-1:0][ADDR_WIDTH-1:0] len_r;

  // FSM and grant registers
  sched_state_t          state_r;
  sched_state_t          state_s;
  logic                  latch_s;
  logic                  done_s;
  logic [3:0]            rr_ptr_r;
  logic [3:0]            sel_r;
  logic [ADDR_WIDTH-1:0] glen_r;
  logic                  grant_valid_r;
  logic                  busy_r;

  // Round-robin pick
  logic                  pick_found_s;
  logic [3:0]            pick_idx_s;

  // Pointer differences; read-side free space is capacity minus level.
  for (genvar k = 0; k < SIDE_COUNT; k++) begin : g_level
    assign wr_level_s[k] = ADDR_WIDTH'(fifo_level(
                             MAX_ADDR_WIDTH'(write_in_addrs[k*ADDR_WIDTH +: ADDR_WIDTH]),
                             MAX_ADDR_WIDTH'(write_out_addrs[k*ADDR_WIDTH +: ADDR_WIDTH])));
    assign rd_free_s[k]  = CAPACITY - ADDR_WIDTH'(fifo_level(
                             MAX_ADDR_WIDTH'(read_in_addrs[k*ADDR_WIDTH +: ADDR_WIDTH]),
                             MAX_ADDR_WIDTH'(read_out_addrs[k*ADDR_WIDTH +: ADDR_WIDTH])));
  end

  // Eligibility and burst length for every channel.
  always_comb begin
    elig_s = '0;
    len_s  = '0;
    for (int k = 0; k < SIDE_COUNT; k++) begin
      // Write side: full burst wins; a flush takes whatever is there (< burst).
      if (chan_enable[k] && (wr_level_s[k] >= BURST_LEN)) begin
        elig_s[k] = 1'b1;
        len_s[k]  = BURST_LEN;
      end else if (chan_enable[k] && flush_req[k] && (wr_level_s[k] != '0)) begin
        elig_s[k] = 1'b1;
        len_s[k]  = wr_level_s[k];
      end else begin
        elig_s[k] = 1'b0;
        len_s[k]  = '0;
      end
      // Read side: room for a whole burst.
      if (chan_enable[SIDE_COUNT+k] && (rd_free_s[k] >= BURST_LEN)) begin
        elig_s[SIDE_COUNT+k] = 1'b1;
        len_s[SIDE_COUNT+k]  = BURST_LEN;
      end else begin
        elig_s[SIDE_COUNT+k] = 1'b0;
        len_s[SIDE_COUNT+k]  = '0;
      end
    end
  end

  // Eligibility pipeline register, refreshed every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elig_r <= '0;
      len_r  <= '0;
    end else begin
      elig_r <= elig_s;
      len_r  <= len_s;
    end
  end

  rr_pick16 u_pick (
    .req   (elig_r),
    .start (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state logic: latch a grant in IDLE, hold it in OFFER until accepted.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_s = ST_OFFER;
          latch_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (gnt.grant_ready) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_OFFER;
        end
      end
      ST_BUSY: begin
        if (gnt.xfer_done) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, grant latch, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= 4'd0;
      sel_r         <= 4'd0;
      glen_r        <= '0;
      grant_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      grant_valid_r <= (state_s == ST_OFFER);
      busy_r        <= (state_s == ST_BUSY);
      if (latch_s) begin
        sel_r  <= pick_idx_s;
        glen_r <= len_r[pick_idx_s];
      end
      // Pointer moves past the serviced channel; 4-bit add wraps 15 -> 0.
      if (done_s) begin
        rr_ptr_r <= sel_r + 4'd1;
      end
    end
  end

  assign gnt.grant_valid = grant_valid_r;
  assign gnt.busy        = busy_r;
  assign gnt.grant_dir   = sel_r[3] ? DIR_READ : DIR_WRITE;
  assign gnt.grant_chan  = sel_r[2:0];
  assign gnt.grant_len   = glen_r;

endmodule

// File: tb/tb_fifo_service_scheduler.sv
module tb_fifo_service_scheduler;
  import fifo_sched_pkg::*;

  localparam int AW = 11;
  localparam int BB = 64;

  logic clk;
  logic reset;
  logic [8*AW-1:0] write_in_addrs;
  logic [8*AW-1:0] write_out_addrs;
  logic [8*AW-1:0] read_in_addrs;
  logic [8*AW-1:0] read_out_addrs;
  logic [15:0] chan_enable;
  logic [7:0]  flush_req;

  int total;
  int bad;

  fifo_service_scheduler_if #(.ADDR_WIDTH(AW)) gnt_if ();

  fifo_service_scheduler #(.BURST_BYTES(BB), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .write_in_addrs  (write_in_addrs),
    .write_out_addrs (write_out_addrs),
    .read_in_addrs   (read_in_addrs),
    .read_out_addrs  (read_out_addrs),
    .chan_enable     (chan_enable),
    .flush_req       (flush_req),
    .gnt             (gnt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    write_in_addrs  = '0;
    write_out_addrs = '0;
    read_in_addrs   = '0;
    read_out_addrs  = '0;
    chan_enable     = 16'h0000;
    flush_req       = 8'h00;
    gnt_if.grant_ready = 1'b0;
    gnt_if.xfer_done   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for grant_valid, sampling on falling edges.
  task automatic wait_valid(input int max_cycles, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
      if (gnt_if.grant_valid === 1'b1) seen = 1'b1;
    end
  endtask

  // Accept the current offer, then pulse xfer_done after a short busy period.
  task automatic accept_and_finish(input logic [15:0] enable_after);
    gnt_if.grant_ready = 1'b1;
    @(negedge clk);
    gnt_if.grant_ready = 1'b0;
    chan_enable = enable_after;
    @(negedge clk);
    gnt_if.xfer_done = 1'b1;
    @(negedge clk);
    gnt_if.xfer_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #3;
    total++;
    if ({gnt_if.grant_valid, gnt_if.busy, gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b c=%0d l=%0d, want all 0",
               gnt_if.grant_valid, gnt_if.busy, gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // Stray handshake inputs in IDLE with nothing eligible must be ignored.
    @(negedge clk);
    gnt_if.xfer_done   = 1'b1;
    gnt_if.grant_ready = 1'b1;
    @(negedge clk);
    gnt_if.xfer_done   = 1'b0;
    gnt_if.grant_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({gnt_if.grant_valid, gnt_if.busy} !== 2'b00 || dut.rr_ptr_r !== 4'd0) begin
      bad++;
      $display("FAIL idle_ignore: got v=%b b=%b rr=%0d, want 0 0 0",
               gnt_if.grant_valid, gnt_if.busy, dut.rr_ptr_r);
    end
  endtask

  task automatic test_basic_write();
    bit seen;
    int cyc;
    do_reset();
    chan_enable = 16'h0004;
    write_in_addrs[2*AW +: AW] = 11'd64;
    wait_valid(8, seen, cyc);
    total++;
    if (!seen || cyc != 2) begin
      bad++;
      $display("FAIL basic_latency: got seen=%0d cycles=%0d, want 1 2", seen, cyc);
    end
    total++;
    if ({gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len} !== {1'b0, 3'd2, 11'd64}) begin
      bad++;
      $display("FAIL basic_grant: got d=%b c=%0d l=%0d, want 0 2 64",
               gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len);
    end
    gnt_if.grant_ready = 1'b1;
    @(negedge clk);
    gnt_if.grant_ready = 1'b0;
    total++;
    if ({gnt_if.grant_valid, gnt_if.busy} !== 2'b01) begin
      bad++;
      $display("FAIL basic_busy: got v=%b b=%b, want 0 1", gnt_if.grant_valid, gnt_if.busy);
    end
    chan_enable = 16'h0000;
    @(negedge clk);
    gnt_if.xfer_done = 1'b1;
    @(negedge clk);
    gnt_if.xfer_done = 1'b0;
    total++;
    if (gnt_if.busy !== 1'b0 || dut.rr_ptr_r !== 4'd3) begin
      bad++;
      $display("FAIL basic_done: got busy=%b rr=%0d, want 0 3", gnt_if.busy, dut.rr_ptr_r);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int cyc;
    logic [3:0] got;
    do_reset();
    for (int k = 0; k < 8; k++) write_in_addrs[k*AW +: AW] = 11'd64;
    chan_enable = 16'hFFFF;
    gnt_if.grant_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      wait_valid(10, seen, cyc);
      got = {gnt_if.grant_dir, gnt_if.grant_chan};
      total++;
      if (!seen || got !== 4'(n % 16)) begin
        bad++;
        $display("FAIL rr_order[%0d]: got seen=%0d idx=%0d, want idx %0d", n, seen, got, n % 16);
      end
      @(negedge clk);
      @(negedge clk);
      gnt_if.xfer_done = 1'b1;
      @(negedge clk);
      gnt_if.xfer_done = 1'b0;
      if (n == 15) begin
        total++;
        if (dut.rr_ptr_r !== 4'd0) begin
          bad++;
          $display("FAIL rr_wrap: got rr=%0d, want 0", dut.rr_ptr_r);
        end
      end
    end
    gnt_if.grant_ready = 1'b0;
  endtask

  task automatic test_flush();
    bit seen;
    int cyc;
    do_reset();
    chan_enable = 16'h0020;
    write_in_addrs[5*AW +: AW] = 11'd20;
    wait_valid(6, seen, cyc);
    total++;
    if (seen) begin
      bad++;
      $display("FAIL flush_off: got grant chan=%0d, want no grant", gnt_if.grant_chan);
    end
    flush_req = 8'h20;
    wait_valid(8, seen, cyc);
    total++;
    if (!seen || {gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len} !== {1'b0, 3'd5, 11'd20}) begin
      bad++;
      $display("FAIL flush_len: got seen=%0d d=%b c=%0d l=%0d, want 0 5 20",
               seen, gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len);
    end
    accept_and_finish(16'h0000);
  endtask

  task automatic test_read_space();
    bit seen;
    int cyc;
    do_reset();
    chan_enable = 16'h0200;
    read_in_addrs[1*AW +: AW]  = 11'd5;
    read_out_addrs[1*AW +: AW] = 11'd6;
    wait_valid(6, seen, cyc);
    total++;
    if (seen) begin
      bad++;
      $display("FAIL read_full: got grant d=%b c=%0d, want no grant", gnt_if.grant_dir, gnt_if.grant_chan);
    end
    read_out_addrs[1*AW +: AW] = 11'd5;
    wait_valid(8, seen, cyc);
    total++;
    if (!seen || {gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len} !== {1'b1, 3'd1, 11'd64}) begin
      bad++;
      $display("FAIL read_empty: got seen=%0d d=%b c=%0d l=%0d, want 1 1 64",
               seen, gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len);
    end
    accept_and_finish(16'h0000);
  endtask

  task automatic test_ptr_wrap();
    bit seen;
    int cyc;
    do_reset();
    chan_enable = 16'h0008;
    flush_req   = 8'h08;
    write_in_addrs[3*AW +: AW]  = 11'd3;
    write_out_addrs[3*AW +: AW] = 11'd2045;
    wait_valid(8, seen, cyc);
    total++;
    if (!seen || {gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len} !== {1'b0, 3'd3, 11'd6}) begin
      bad++;
      $display("FAIL wrap_len: got seen=%0d d=%b c=%0d l=%0d, want 0 3 6",
               seen, gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len);
    end
    accept_and_finish(16'h0000);
  endtask

  task automatic test_hold_and_abort();
    bit seen;
    int cyc;
    int unstable;
    do_reset();
    chan_enable = 16'h0001;
    write_in_addrs[0 +: AW] = 11'd64;
    wait_valid(8, seen, cyc);
    chan_enable = 16'h0000;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({gnt_if.grant_valid, gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len} !== {1'b1, 1'b0, 3'd0, 11'd64})
        unstable++;
    end
    total++;
    if (!seen || unstable != 0) begin
      bad++;
      $display("FAIL offer_hold: got seen=%0d unstable_cycles=%0d, want 1 0", seen, unstable);
    end
    gnt_if.grant_ready = 1'b1;
    @(negedge clk);
    gnt_if.grant_ready = 1'b0;
    total++;
    if (gnt_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL hold_busy: got busy=%b, want 1", gnt_if.busy);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({gnt_if.grant_valid, gnt_if.busy, gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got v=%b b=%b d=%b c=%0d l=%0d, want all 0",
               gnt_if.grant_valid, gnt_if.busy, gnt_if.grant_dir, gnt_if.grant_chan, gnt_if.grant_len);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (dut.state_r !== ST_IDLE || {gnt_if.grant_valid, gnt_if.busy} !== 2'b00) begin
      bad++;
      $display("FAIL abort_idle: got state=%0d v=%b b=%b, want IDLE 0 0",
               dut.state_r, gnt_if.grant_valid, gnt_if.busy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_flush();
    test_read_space();
    test_ptr_wrap();
    test_hold_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_service_scheduler.md
# fifo_service_scheduler

Decides which tracking FIFO the memory arbitrator services next and offers one burst grant at a time. Eligibility comes from each FIFO's in/out address pair: data waiting on the 8 write-side FIFOs (EP2→RAM, ADC→RAM), and free space on the 8 read-side FIFOs (RAM→DAC, RAM→EP6). Channels are chosen round-robin over 16 channels. The block sits between the tracking FIFO address buses and the memory arbitrator's transfer sequencer.

## Interface
Parameters:
- `BURST_BYTES`, default 64: nominal transfer size in bytes; legal range 1..1024.
- `ADDR_WIDTH`, default 11: tracking FIFO address width; FIFO depth is 2^ADDR_WIDTH.

Ports:
- `clk` in 1: system clock; every input is synchronous to it.
- `reset` in 1: asynchronous, active-low reset.
- `write_in_addrs` in 8*ADDR_WIDTH: write-side FIFO write pointers; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `write_out_addrs` in 8*ADDR_WIDTH: write-side FIFO read pointers.
- `read_in_addrs` in 8*ADDR_WIDTH: read-side FIFO write pointers.
- `read_out_addrs` in 8*ADDR_WIDTH: read-side FIFO read pointers.
- `chan_enable` in 16: bit c enables channel c. Bits 0–7 are write channels 0–7; bits 8–15 are read channels 0–7.
- `flush_req` in 8: write channel k may be granted a partial burst.
- `grant_valid` out 1: a grant is being offered.
- `grant_ready` in 1: the arbitrator accepts the offered grant.
- `grant_dir` out 1: 0 means write-side (FIFO→RAM); 1 means read-side (RAM→FIFO).
- `grant_chan` out 3: FIFO index 0–7 within the side given by `grant_dir`.
- `grant_len` out ADDR_WIDTH: number of bytes to transfer.
- `xfer_done` in 1: one-cycle pulse from the arbitrator when the accepted transfer is complete.
- `busy` out 1: a grant has been accepted and is not yet done.

## Operation
- Level is `(in_addr - out_addr) mod 2^ADDR_WIDTH`, computed in unsigned ADDR_WIDTH-bit arithmetic. Usable capacity is 2^ADDR_WIDTH − 1.
- Write channel k is eligible when `chan_enable[k]` is set and either:
  - level ≥ BURST_BYTES, giving `len = BURST_BYTES`; or
  - `flush_req[k]` is set and level > 0, giving `len = min(level, BURST_BYTES)`.
- Read channel k is eligible when `chan_enable[8+k]` is set and free space ≥ BURST_BYTES, where free = (2^ADDR_WIDTH − 1) − level. Its `len = BURST_BYTES`.
- The eligibility vector (16 bits) and the per-channel lengths are registered every cycle.
- Round-robin pointer `rr_ptr` (4 bits) selects the first eligible channel at or after `rr_ptr`, wrapping 15→0.
- States:
  - IDLE: if any channel is eligible, latch chan/dir/len and go to OFFER. Otherwise stay.
  - OFFER: `grant_valid=1`. Outputs are held stable until `grant_ready`, then go to BUSY.
  - BUSY: `busy=1`; on `xfer_done` go to IDLE and set `rr_ptr = {dir,chan} + 1` (mod 16).
- No retraction: if a channel becomes ineligible or disabled while in OFFER, the grant stays valid until it is accepted.
- `xfer_done` outside BUSY is ignored. `grant_ready` outside OFFER is ignored.
- In BUSY, the arbitrator must not start a second transfer. The scheduler issues at most one outstanding grant.

## Timing
- Reset values:
  - `grant_valid=0`, `grant_dir=0`, `grant_chan=0`, `grant_len=0`, `busy=0`.
  - `rr_ptr=0`, state IDLE, eligibility register 0.
- Latency from an address change to the eligibility register: 1 cycle. From eligibility register to `grant_valid`: 1 cycle (IDLE→OFFER). An input change therefore yields `grant_valid` 2 cycles later.
- The handshake completes on the rising edge where `grant_valid && grant_ready`. `busy` rises the next cycle, and `grant_valid` falls the same cycle.
- `xfer_done` in BUSY: the scheduler is back in IDLE the next cycle. The earliest next `grant_valid` is 2 cycles after `xfer_done`. Eligibility is re-sampled after pointer motion, so the arbitrator sees fresh levels.
- Back-to-back `grant_ready` held high: a grant is accepted every cycle it is offered.
- Reset asserted mid-OFFER or mid-BUSY returns all outputs to reset values immediately (asynchronously). The arbitrator must treat this as an aborted transfer.
- Pointer wrap: a read channel 7 grant (index 15) sets `rr_ptr=0`.

## Structure
- Package `fifo_sched_pkg` holds:
  - `CHAN_COUNT=16`.
  - The `DIR_WRITE=0` / `DIR_READ=1` encodings.
  - A function computing level mod 2^ADDR_WIDTH.
- Sub-module `rr_pick16`: a combinational rotating priority encoder. Inputs are a 16-bit request and a 4-bit start; outputs are `found` and a 4-bit index.
- Top level contains the level/eligibility pipeline register, the three-state FSM and `rr_ptr`.

## Test plan
- Write channel 2 level rises from 0 to 64 (BURST_BYTES=64) → `grant_valid` 2 cycles later with dir=0, chan=2, len=64. Accept, pulse done → `rr_ptr=3`.
- All 16 channels eligible, `grant_ready` high, done pulsed 3 cycles after each accept → grant order is 0,1,…,15,0.
- Write channel 5 level 20, `flush_req[5]=1` → len=20. With `flush_req=0`, there is no grant.
- Read channel 1 with in=5, out=6 (level 2047, free 0) → never granted. With out=5 (level 0, free 2047) → granted, dir=1, chan=1, len=64.
- Pointer wrap: in=3, out=2045 gives level 6 (mod 2048). A flushed write channel gets len=6.
- Hold `grant_ready` low for 10 cycles while the channel is disabled mid-OFFER → outputs stay stable. Assert `reset` low during BUSY → all outputs are 0 immediately, and the FSM is in IDLE on release.
